// File: rtl/load_store_unit.sv
// MIPS load/store unit: turns lb/lbu/lh/lhu/lw/sb/sh/sw requests into word-wide data_mem
// accesses, with sub-word extraction/extension, read-modify-write stores and misalignment detection.
module load_store_unit #(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misaligned,
    output logic              mem_r,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDC,
        S_WR,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_we;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_misaligned;

    logic                w_accept;
    logic                w_req_misaligned;
    logic [1:0]          w_lane;
    logic                w_half_sel;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DATA_W-1:0]   w_extended;
    logic [DATA_W-1:0]   w_merged;
    logic [ADDR_W-1:0]   w_word_index;

    assign w_accept = req_valid && !rst && (r_state == S_IDLE);

    // Size 11 is never a legal access, so it shares the misaligned path.
    always_comb begin
        w_req_misaligned = 1'b0;
        case (req_size)
            SIZE_BYTE: w_req_misaligned = 1'b0;
            SIZE_HALF: w_req_misaligned = req_addr[0];
            SIZE_WORD: w_req_misaligned = (req_addr[1:0] != 2'b00);
            default:   w_req_misaligned = 1'b1;
        endcase
    end

    // Lane selection from the latched address; big-endian mirrors lanes within the word.
    assign w_lane       = BIG_ENDIAN ? ~r_addr[1:0] : r_addr[1:0];
    assign w_half_sel   = BIG_ENDIAN ? ~r_addr[1] : r_addr[1];
    assign w_byte       = mem_rdata[{w_lane, 3'b000} +: 8];
    assign w_half       = mem_rdata[{w_half_sel, 4'b0000} +: 16];
    assign w_word_index = {2'b00, r_addr[ADDR_W-1:2]};

    always_comb begin
        w_extended = mem_rdata;
        case (r_size)
            SIZE_BYTE: w_extended = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            SIZE_HALF: w_extended = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            default:   w_extended = mem_rdata;
        endcase
    end

    // Sub-word store: overwrite only the addressed lane(s) of the captured word.
    always_comb begin
        w_merged = mem_rdata;
        if (r_size == SIZE_BYTE) begin
            w_merged[{w_lane, 3'b000} +: 8] = r_data[7:0];
        end else begin
            w_merged[{w_half_sel, 4'b0000} +: 16] = r_data[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_misaligned = 1'b0;
        mem_r           = 1'b0;
        mem_w           = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = !rst;
                if (w_accept) begin
                    if (w_req_misaligned) begin
                        w_next = S_RESP;
                    end else if (req_we && (req_size == SIZE_WORD)) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD: begin
                mem_r    = !rst;
                mem_addr = w_word_index;
                w_next   = S_RDC;
            end
            S_RDC: begin
                mem_r    = !rst;
                mem_addr = w_word_index;
                w_next   = r_we ? S_WR : S_RESP;
            end
            S_WR: begin
                mem_w     = !rst;
                mem_addr  = w_word_index;
                mem_wdata = r_data;
                w_next    = S_RESP;
            end
            S_RESP: begin
                mem_addr        = w_word_index;
                resp_valid      = !rst;
                resp_misaligned = !rst && r_misaligned;
                resp_rdata      = (rst || r_we || r_misaligned) ? '0 : r_data;
                w_next          = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch; r_data holds store data until RDC, then the extended load or merged word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we         <= req_we;
                r_size       <= req_size;
                r_signed     <= req_signed;
                r_addr       <= req_addr;
                r_data       <= req_wdata;
                r_misaligned <= w_req_misaligned;
            end
            if (r_state == S_RDC) begin
                r_data <= r_we ? w_merged : w_extended;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: little-endian and big-endian instances, each backed by
// a small synchronous-read word memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        le_valid;
    logic        be_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        le_ready, le_resp_valid, le_resp_mis, le_mem_r, le_mem_w;
    logic [31:0] le_resp_rdata, le_mem_addr, le_mem_wdata, le_mem_rdata;
    logic        be_ready, be_resp_valid, be_resp_mis, be_mem_r, be_mem_w;
    logic [31:0] be_resp_rdata, be_mem_addr, be_mem_wdata, be_mem_rdata;

    logic [31:0] le_mem [16];
    logic [31:0] be_mem [16];

    int checks = 0;
    int errors = 0;

    load_store_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst(rst),
        .req_valid(le_valid), .req_ready(le_ready), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(le_resp_valid), .resp_rdata(le_resp_rdata), .resp_misaligned(le_resp_mis),
        .mem_r(le_mem_r), .mem_w(le_mem_w), .mem_addr(le_mem_addr),
        .mem_wdata(le_mem_wdata), .mem_rdata(le_mem_rdata)
    );

    load_store_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst(rst),
        .req_valid(be_valid), .req_ready(be_ready), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(be_resp_valid), .resp_rdata(be_resp_rdata), .resp_misaligned(be_resp_mis),
        .mem_r(be_mem_r), .mem_w(be_mem_w), .mem_addr(be_mem_addr),
        .mem_wdata(be_mem_wdata), .mem_rdata(be_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (le_mem_w) le_mem[le_mem_addr[3:0]] <= le_mem_wdata;
        if (le_mem_r) le_mem_rdata <= le_mem[le_mem_addr[3:0]];
        if (be_mem_w) be_mem[be_mem_addr[3:0]] <= be_mem_wdata;
        if (be_mem_r) be_mem_rdata <= be_mem[be_mem_addr[3:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present a request for one accept cycle; returns one step into cycle N+1.
    task automatic issue(input bit be, input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        if (be) be_valid = 1'b1; else le_valid = 1'b1;
        step();
        le_valid = 1'b0;
        be_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (le_ready !== 1'b0 || be_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got le=%b be=%b want 0", le_ready, be_ready);
        end
        checks++;
        if ({le_resp_valid, le_resp_mis, le_mem_r, le_mem_w} !== 4'b0000 ||
            le_resp_rdata !== 32'd0 || le_mem_addr !== 32'd0 || le_mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%b mis=%b r=%b w=%b rd=%h a=%h wd=%h want all 0",
                     le_resp_valid, le_resp_mis, le_mem_r, le_mem_w, le_resp_rdata, le_mem_addr, le_mem_wdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (le_ready !== 1'b1 || be_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got le=%b be=%b want 1", le_ready, be_ready);
        end
    endtask

    task automatic test_sw_lw;
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF);
        checks++;
        if (le_mem_w !== 1'b1 || le_mem_r !== 1'b0 || le_mem_addr !== 32'd2 || le_mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_write: got w=%b r=%b a=%h wd=%h want w=1 r=0 a=2 wd=deadbeef",
                     le_mem_w, le_mem_r, le_mem_addr, le_mem_wdata);
        end
        step();
        checks++;
        if (le_resp_valid !== 1'b1 || le_resp_rdata !== 32'd0 || le_resp_mis !== 1'b0 || le_ready !== 1'b0) begin
            errors++;
            $display("FAIL sw_resp: got rv=%b rd=%h mis=%b rdy=%b want rv=1 rd=0 mis=0 rdy=0",
                     le_resp_valid, le_resp_rdata, le_resp_mis, le_ready);
        end
        step();
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
        checks++;
        if (le_mem_r !== 1'b1 || le_mem_w !== 1'b0 || le_mem_addr !== 32'd2) begin
            errors++;
            $display("FAIL lw_rd: got r=%b w=%b a=%h want r=1 w=0 a=2", le_mem_r, le_mem_w, le_mem_addr);
        end
        step();
        checks++;
        if (le_mem_r !== 1'b1 || le_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lw_rdc: got r=%b rv=%b want r=1 rv=0", le_mem_r, le_resp_valid);
        end
        step();
        checks++;
        if (le_resp_valid !== 1'b1 || le_resp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_resp: got rv=%b rd=%h want rv=1 rd=deadbeef", le_resp_valid, le_resp_rdata);
        end
        step();
    endtask

    task automatic test_sb_merge;
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'd4, 32'h11223344);
        step();
        step();
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'd5, 32'hFFFFFFAB);
        checks++;
        if (le_mem_r !== 1'b1 || le_mem_w !== 1'b0) begin
            errors++;
            $display("FAIL sb_rd: got r=%b w=%b want r=1 w=0", le_mem_r, le_mem_w);
        end
        step();
        step();
        checks++;
        if (le_mem_w !== 1'b1 || le_mem_r !== 1'b0 || le_mem_addr !== 32'd1 || le_mem_wdata !== 32'h1122AB44) begin
            errors++;
            $display("FAIL sb_write: got w=%b r=%b a=%h wd=%h want w=1 r=0 a=1 wd=1122ab44",
                     le_mem_w, le_mem_r, le_mem_addr, le_mem_wdata);
        end
        step();
        checks++;
        if (le_resp_valid !== 1'b1 || le_resp_rdata !== 32'd0 || le_mem[1] !== 32'h1122AB44) begin
            errors++;
            $display("FAIL sb_resp: got rv=%b rd=%h word1=%h want rv=1 rd=0 word1=1122ab44",
                     le_resp_valid, le_resp_rdata, le_mem[1]);
        end
        step();
    endtask

    task automatic test_extend;
        logic [1:0]  sizes [4];
        logic        sgns  [4];
        logic [31:0] exps  [4];
        sizes = '{2'b00, 2'b00, 2'b01, 2'b01};
        sgns  = '{1'b1, 1'b0, 1'b1, 1'b0};
        exps  = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h000080FF};
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'd4, 32'h80FF7F01);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b0, sizes[i], sgns[i], 32'd6, 32'h0);
            step();
            step();
            checks++;
            if (le_resp_valid !== 1'b1 || le_resp_rdata !== exps[i]) begin
                errors++;
                $display("FAIL extend_%0d: got rv=%b rd=%h want rv=1 rd=%h", i, le_resp_valid, le_resp_rdata, exps[i]);
            end
            step();
        end
    endtask

    task automatic test_misaligned;
        logic [1:0]  sizes [3];
        logic [31:0] addrs [3];
        logic        wes   [3];
        sizes = '{2'b10, 2'b01, 2'b11};
        addrs = '{32'd2, 32'd3, 32'd4};
        wes   = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, wes[i], sizes[i], 1'b1, addrs[i], 32'h12345678);
            checks++;
            if (le_resp_valid !== 1'b1 || le_resp_mis !== 1'b1 || le_resp_rdata !== 32'd0 ||
                le_mem_r !== 1'b0 || le_mem_w !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_%0d: got rv=%b mis=%b rd=%h r=%b w=%b want rv=1 mis=1 rd=0 r=0 w=0",
                         i, le_resp_valid, le_resp_mis, le_resp_rdata, le_mem_r, le_mem_w);
            end
            step();
            checks++;
            if (le_ready !== 1'b1 || le_resp_valid !== 1'b0 || le_mem_r !== 1'b0 || le_mem_w !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_after_%0d: got rdy=%b rv=%b r=%b w=%b want rdy=1 rv=0 r=0 w=0",
                         i, le_ready, le_resp_valid, le_mem_r, le_mem_w);
            end
        end
        checks++;
        if (le_mem[1] !== 32'h80FF7F01) begin
            errors++;
            $display("FAIL misaligned_mem: got word1=%h want 80ff7f01", le_mem[1]);
        end
    endtask

    task automatic test_reset_abort;
        bit seen_w = 1'b0;
        bit seen_v = 1'b0;
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'd4, 32'h5555BEEF);
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (le_mem_r !== 1'b0 || le_mem_w !== 1'b0) begin
            errors++;
            $display("FAIL abort_gate: got r=%b w=%b want r=0 w=0 during reset", le_mem_r, le_mem_w);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (le_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b want 1", le_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (le_mem_w === 1'b1) seen_w = 1'b1;
            if (le_resp_valid === 1'b1) seen_v = 1'b1;
            step();
        end
        checks++;
        if (seen_w || seen_v || le_mem[1] !== 32'h80FF7F01) begin
            errors++;
            $display("FAIL abort_effect: got w_seen=%b v_seen=%b word1=%h want 0 0 80ff7f01",
                     seen_w, seen_v, le_mem[1]);
        end
    endtask

    task automatic test_back_to_back;
        req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'd4; req_wdata = 32'h0;
        le_valid = 1'b1;
        step();
        req_addr = 32'd5;
        step();
        step();
        checks++;
        if (le_resp_valid !== 1'b1 || le_resp_rdata !== 32'h00000001 || le_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got rv=%b rd=%h rdy=%b want rv=1 rd=00000001 rdy=0",
                     le_resp_valid, le_resp_rdata, le_ready);
        end
        step();
        checks++;
        if (le_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b want 1", le_ready);
        end
        step();
        le_valid = 1'b0;
        step();
        step();
        checks++;
        if (le_resp_valid !== 1'b1 || le_resp_rdata !== 32'h0000007F) begin
            errors++;
            $display("FAIL b2b_second: got rv=%b rd=%h want rv=1 rd=0000007f", le_resp_valid, le_resp_rdata);
        end
        step();
    endtask

    task automatic test_big_endian;
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'd4, 32'h11223344);
        step();
        step();
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'd4, 32'h0);
        step();
        step();
        checks++;
        if (be_resp_valid !== 1'b1 || be_resp_rdata !== 32'h00000011) begin
            errors++;
            $display("FAIL be_lbu: got rv=%b rd=%h want rv=1 rd=00000011", be_resp_valid, be_resp_rdata);
        end
        step();
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'd6, 32'h0);
        step();
        step();
        checks++;
        if (be_resp_valid !== 1'b1 || be_resp_rdata !== 32'h00003344) begin
            errors++;
            $display("FAIL be_lhu: got rv=%b rd=%h want rv=1 rd=00003344", be_resp_valid, be_resp_rdata);
        end
        step();
        issue(1'b1, 1'b1, 2'b00, 1'b0, 32'd7, 32'h000000EE);
        step();
        step();
        checks++;
        if (be_mem_w !== 1'b1 || be_mem_wdata !== 32'h112233EE) begin
            errors++;
            $display("FAIL be_sb_write: got w=%b wd=%h want w=1 wd=112233ee", be_mem_w, be_mem_wdata);
        end
        step();
        step();
        checks++;
        if (be_mem[1] !== 32'h112233EE || le_mem[1] !== 32'h80FF7F01) begin
            errors++;
            $display("FAIL be_sb_mem: got be=%h le=%h want be=112233ee le=80ff7f01", be_mem[1], le_mem[1]);
        end
    endtask

    initial begin
        rst        = 1'b1;
        le_valid   = 1'b0;
        be_valid   = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        test_reset();
        test_sw_lw();
        test_sb_merge();
        test_extend();
        test_misaligned();
        test_reset_abort();
        test_back_to_back();
        test_big_endian();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
